// File: rtl/wb4_sync_fifo_n_to_1.sv
// wb4_sync_fifo_n_to_1: single-clock Wishbone B4 pipelined FIFO. Each write
// takes one wide word of P_RATIO units, and each read returns one unit.
// Build option: define WB4_FIFO_N_TO_1_MSB_FIRST_EN to emit the most-significant
// unit of each word first. By default the least-significant unit comes first.
module wb4_sync_fifo_n_to_1 #(
  parameter int P_DATA_MSB = 7,
  parameter int P_RATIO    = 4,
  parameter int P_DEPTH    = 16
) (
  input  logic                                 i_wb4_sclk,
  input  logic                                 i_wb4_srst,
  input  logic                                 i_wb4_in_scyc,
  input  logic                                 i_wb4_in_sstb,
  output logic                                 o_wb4_in_sack,
  input  logic [P_RATIO*(P_DATA_MSB+1)-1:0]    i_wb4_in_sdata,
  output logic                                 o_wb4_in_sstall,
  input  logic                                 i_wb4_out_scyc,
  input  logic                                 i_wb4_out_sstb,
  output logic                                 o_wb4_out_sack,
  output logic [P_DATA_MSB:0]                  o_wb4_out_sdata,
  output logic                                 o_wb4_out_sstall,
  output logic [$clog2(P_DEPTH):0]             o_level
);

  localparam int UW = P_DATA_MSB + 1;
  localparam int WW = P_RATIO * UW;
  localparam int AW = $clog2(P_DEPTH);
  localparam int IW = $clog2(P_RATIO);

  logic [WW-1:0] mem [P_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [IW-1:0] uidx, sel;
  logic [WW-1:0] head;
  logic          empty, full, we, re, last;

  // Flags come only from registered pointers, so the stalls have no input path.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign we   = i_wb4_in_scyc & i_wb4_in_sstb & ~full;
  assign re   = i_wb4_out_scyc & i_wb4_out_sstb & ~empty;
  // P_RATIO is a power of 2, so "all ones" is the final unit of the word.
  assign last = &uidx;

`ifdef WB4_FIFO_N_TO_1_MSB_FIRST_EN
  // ~uidx equals P_RATIO-1-uidx because the index width is exactly log2(P_RATIO).
  assign sel = ~uidx;
`else
  assign sel = uidx;
`endif

  assign head = mem[rptr[AW-1:0]];

  assign o_wb4_in_sstall  = full;
  assign o_wb4_out_sstall = empty;
  assign o_level          = wptr - rptr;

  // Word storage. It has no reset, so its contents survive a reset.
  always_ff @(posedge i_wb4_sclk) begin
    if (we) mem[wptr[AW-1:0]] <= i_wb4_in_sdata;
  end

  // Pointers and unit index. The head word pops when its final unit is read.
  always_ff @(posedge i_wb4_sclk or posedge i_wb4_srst) begin
    if (i_wb4_srst) begin
      wptr <= '0;
      rptr <= '0;
      uidx <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) begin
        uidx <= uidx + 1'b1;
        if (last) rptr <= rptr + 1'b1;
      end
    end
  end

  // Registered acknowledges and read data. The data register holds between reads.
  always_ff @(posedge i_wb4_sclk or posedge i_wb4_srst) begin
    if (i_wb4_srst) begin
      o_wb4_in_sack   <= 1'b0;
      o_wb4_out_sack  <= 1'b0;
      o_wb4_out_sdata <= '0;
    end else begin
      o_wb4_in_sack  <= we;
      o_wb4_out_sack <= re;
      if (re) o_wb4_out_sdata <= head[sel*UW +: UW];
    end
  end

endmodule
